// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix scanner with frame debounce.
// Ports: clk, rst (sync, active-low), col[3:0] (active-low, async)
//        row[3:0] (active-low one-hot drive), key_code[3:0] (row*4+col),
//        key_valid (1-cycle press event), key_held (reported key still down)
module keypad_scanner #(
  parameter int INPUT_FREQ      = 50000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV = INPUT_FREQ / SCAN_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DEBOUNCE_FRAMES);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [DW-1:0] div;
  logic [1:0]    row_idx;
  logic [15:0]   snap;
  logic [15:0]   prev;
  logic [15:0]   deb;
  logic [15:0]   frame;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          upd;
  logic          tick;
  logic          frame_end;

  state_t        state;
  state_t        state_next;
  logic [3:0]    code_next;
  logic          valid_next;
  logic          held_next;

  logic          no_key;
  logic          one_hot;
  logic          multi;
  logic [3:0]    idx;

  assign tick      = (div == DIV_LAST);
  assign frame_end = tick && (row_idx == 2'd3);
  assign row       = ~(4'b0001 << row_idx);

  // Frame as it will look once the current row's sample is merged in;
  // at frame end this is the completed 16-bit frame.
  always_comb begin
    frame = snap;
    frame[{row_idx, 2'b00} +: 4] = ~col_sync;
  end

  always_comb begin
    if (frame == prev) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end else begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
      div      <= '0;
      row_idx  <= '0;
      snap     <= '0;
      prev     <= '0;
      deb      <= '0;
      cnt      <= '0;
      upd      <= 1'b0;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
      upd      <= 1'b0;
      if (tick) begin
        div     <= '0;
        row_idx <= row_idx + 2'd1;
        snap    <= frame;
      end else begin
        div <= div + DW'(1);
      end
      if (frame_end) begin
        prev <= frame;
        cnt  <= cnt_next;
        if (cnt_next == CNT_MAX && frame != deb) begin
          deb <= frame;
          upd <= 1'b1;
        end
      end
    end
  end

  assign no_key  = (deb == 16'h0000);
  assign one_hot = !no_key && ((deb & (deb - 16'd1)) == 16'h0000);
  assign multi   = !no_key && !one_hot;

  always_comb begin
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (deb[i]) idx = i[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      key_code  <= code_next;
      key_valid <= valid_next;
      key_held  <= held_next;
    end
  end

  // Every update strobe means the debounced state changed, so a
  // reported key is never still valid after one in PRESSED.
  always_comb begin
    state_next = state;
    code_next  = key_code;
    valid_next = 1'b0;
    held_next  = key_held;
    if (upd) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            one_hot: begin
              code_next  = idx;
              valid_next = 1'b1;
              held_next  = 1'b1;
              state_next = PRESSED;
            end
            multi:   state_next = WAIT_RELEASE;
            no_key:  state_next = IDLE;
            default: state_next = IDLE;
          endcase
        end
        PRESSED: begin
          held_next  = 1'b0;
          state_next = no_key ? IDLE : WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (no_key) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a
// 4x4 matrix model; DIV=4 (16-cycle frame), 3 debounce frames.
module tb_keypad_scanner;

  localparam int FREQ = 40;
  localparam int HZ   = 10;
  localparam int DF   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int code;
    int at;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  got;
  logic prev_valid = 1'b0;

  keypad_scanner #(
    .INPUT_FREQ     (FREQ),
    .SCAN_HZ        (HZ),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  // Cycle index since the last reset edge; cyc%16==15 is a frame end.
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_chk++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL valid_b2b: pulse at cyc %0d follows one, need gap",
                 cyc);
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: code %0d at cyc %0d, need none",
                 key_code, cyc);
      end else begin
        got = exp_q.pop_front();
        if (key_code !== got.code[3:0] || cyc != got.at) begin
          n_fail++;
          $display("FAIL pulse: code %0d cyc %0d, need code %0d cyc %0d",
                   key_code, cyc, got.code, got.at);
        end
      end
    end
    prev_valid = (key_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, need finish");
    $fatal(1);
  end

  function automatic void push(input int code, input int at);
    ev_t e;
    e.code = code;
    e.at   = at;
    exp_q.push_back(e);
  endfunction

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic next_frame_start();
    @(negedge clk);
    while (cyc % 16 != 0) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] er;
    rst  = 1'b0;
    keys = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (row !== 4'b1110 || key_code !== 4'd0 ||
        key_valid !== 1'b0 || key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: row %b code %0d v %b h %b, need 1110 0 0 0",
               row, key_code, key_valid, key_held);
    end
    rst = 1'b1;
    repeat (100) begin
      @(negedge clk);
      er = 4'hF;
      er[(cyc / 4) % 4] = 1'b0;
      n_chk++;
      if (row !== er || key_held !== 1'b0 || key_code !== 4'd0) begin
        n_fail++;
        $display("FAIL idle_scan: cyc %0d row %b h %b code %0d, need %b 0 0",
                 cyc, row, key_held, key_code, er);
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_pending: %0d left, need 0", exp_q.size());
    end
  endtask

  task automatic test_single();
    int t;
    next_frame_start();
    t = 16 * (cyc / 16) + 49;
    keys = 16'h0200;
    push(9, t);
    wait_until(t - 1);
    n_chk++;
    if (key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL held_early: %b, need 0", key_held);
    end
    wait_until(t);
    n_chk++;
    if (key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL held_rise: %b, need 1", key_held);
    end
    wait_until(t + 40);
    next_frame_start();
    t = 16 * (cyc / 16) + 49;
    keys = '0;
    wait_until(t - 1);
    n_chk++;
    if (key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL held_keep: %b, need 1", key_held);
    end
    wait_until(t);
    n_chk++;
    if (key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL held_fall: %b, need 0", key_held);
    end
    repeat (64) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0 || key_code !== 4'd9) begin
      n_fail++;
      $display("FAIL single_end: left %0d code %0d, need 0 and 9",
               exp_q.size(), key_code);
    end
  endtask

  task automatic test_bounce();
    int t0;
    next_frame_start();
    t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      keys = (k % 2 == 0) ? 16'h0008 : 16'h0000;
      wait_until(t0 + 10 * (k + 1));
    end
    keys = 16'h0008;
    // Frames seen: P,R,R,P,P,P -> accepted at the 6th frame end.
    push(3, t0 + 97);
    wait_until(t0 + 97 + 16);
    n_chk++;
    if (exp_q.size() != 0 || key_held !== 1'b1 || key_code !== 4'd3) begin
      n_fail++;
      $display("FAIL bounce: left %0d h %b code %0d, need 0 1 3",
               exp_q.size(), key_held, key_code);
    end
    next_frame_start();
    keys = '0;
    repeat (80) @(negedge clk);
    n_chk++;
    if (key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_rel: h %b, need 0", key_held);
    end
  endtask

  task automatic test_multi();
    int t;
    next_frame_start();
    t = 16 * (cyc / 16) + 49;
    keys = 16'h0010;
    push(4, t);
    wait_until(t + 8);
    n_chk++;
    if (key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_first: h %b, need 1", key_held);
    end
    next_frame_start();
    t = 16 * (cyc / 16) + 49;
    keys = 16'h0050;
    wait_until(t - 1);
    n_chk++;
    if (key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_keep: h %b, need 1", key_held);
    end
    wait_until(t);
    n_chk++;
    if (key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_drop: h %b, need 0", key_held);
    end
    wait_until(t + 32);
    next_frame_start();
    keys = 16'h0010;
    repeat (96) @(negedge clk);
    n_chk++;
    if (key_held !== 1'b0 || exp_q.size() != 0 || key_code !== 4'd4) begin
      n_fail++;
      $display("FAIL multi_wait: h %b left %0d code %0d, need 0 0 4",
               key_held, exp_q.size(), key_code);
    end
    next_frame_start();
    keys = '0;
    repeat (80) @(negedge clk);
    next_frame_start();
    t = 16 * (cyc / 16) + 49;
    keys = 16'h8000;
    push(15, t);
    wait_until(t + 8);
    n_chk++;
    if (key_held !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL multi_new: h %b left %0d, need 1 0",
               key_held, exp_q.size());
    end
    next_frame_start();
    keys = '0;
    repeat (80) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t;
    next_frame_start();
    t = 16 * (cyc / 16) + 49;
    keys = 16'h0001;
    push(0, t);
    wait_until(t + 20);
    n_chk++;
    if (key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: h %b, need 1", key_held);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_chk++;
    if (row !== 4'b1110 || key_code !== 4'd0 ||
        key_valid !== 1'b0 || key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_vals: row %b code %0d v %b h %b, need 1110 0 0 0",
               row, key_code, key_valid, key_held);
    end
    push(0, 49);
    wait_until(48);
    n_chk++;
    if (key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_early: h %b, need 0", key_held);
    end
    wait_until(53);
    n_chk++;
    if (key_held !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rmid_again: h %b left %0d, need 1 0",
               key_held, exp_q.size());
    end
    next_frame_start();
    keys = '0;
    repeat (80) @(negedge clk);
  endtask

  task automatic test_divider();
    int f;
    next_frame_start();
    f = cyc / 16;
    wait_until(16 * f + 13);
    keys = 16'h1000;
    push(12, 16 * f + 49);
    wait_until(16 * f + 57);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL div_in: left %0d, need 0", exp_q.size());
    end
    next_frame_start();
    keys = '0;
    repeat (80) @(negedge clk);
    next_frame_start();
    f = cyc / 16;
    wait_until(16 * f + 14);
    keys = 16'h1000;
    push(12, 16 * (f + 1) + 49);
    wait_until(16 * (f + 1) + 57);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL div_out: left %0d, need 0", exp_q.size());
    end
    next_frame_start();
    keys = '0;
    repeat (80) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_multi();
    test_reset_mid();
    test_divider();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
